// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing frame RAM port B among requesters, with a burst lock.
// gnt is combinational; the RAM command is registered one cycle later; rd_valid arrives at grant+1+RD_LATENCY.
module ram_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 3,
    parameter int RD_LATENCY = 2
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          lock_i,
    input  logic [NUM_REQ-1:0]          we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          rd_valid_o,
    output logic [DATA_W-1:0]           rd_data_o,
    output logic                        busy_o,
    output logic [ADDR_W-1:0]           ram_address_o,
    output logic                        ram_write_enabled_o,
    output logic [DATA_W-1:0]           ram_write_data_o,
    input  logic [DATA_W-1:0]           ram_read_data_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   cand;
    logic               gnt_vld;
    logic [NUM_REQ-1:0] rd_tag_d;

    logic [ADDR_W-1:0]  ram_address_q;
    logic               ram_we_q;
    logic [DATA_W-1:0]  ram_wdata_q;
    logic [RD_LATENCY:0][NUM_REQ-1:0] rd_pipe_q;

    // While locked only the owner may win; otherwise search last+1, last+2, ... modulo NUM_REQ.
    always_comb begin
        gnt_o   = '0;
        gnt_vld = 1'b0;
        gnt_idx = owner_q;
        cand    = '0;
        if (!reset_i) begin
            if (busy_q) begin
                if (req_i[owner_q]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = owner_q;
                end
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
                    if (!gnt_vld && req_i[cand]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
        if (gnt_vld) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        last_d   = last_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        rd_tag_d = '0;
        if (gnt_vld) begin
            last_d = gnt_idx;
            // An unlocked grant while busy can only be the owner, so it releases the lock.
            if (lock_i[gnt_idx]) begin
                busy_d  = 1'b1;
                owner_d = gnt_idx;
            end else begin
                busy_d  = 1'b0;
            end
            if (!we_i[gnt_idx]) begin
                rd_tag_d[gnt_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_q        <= LAST_RST;
            owner_q       <= '0;
            busy_q        <= 1'b0;
            ram_address_q <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            rd_pipe_q     <= '0;
        end else begin
            last_q   <= last_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            ram_we_q <= gnt_vld & we_i[gnt_idx];
            if (gnt_vld) begin
                ram_address_q <= addr_i[gnt_idx*ADDR_W +: ADDR_W];
                ram_wdata_q   <= wdata_i[gnt_idx*DATA_W +: DATA_W];
            end
            // Stage 0 lines up with the command register; the last stage lines up with q_b.
            rd_pipe_q[0] <= rd_tag_d;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                rd_pipe_q[k] <= rd_pipe_q[k-1];
            end
        end
    end

    assign busy_o              = busy_q;
    assign ram_address_o       = ram_address_q;
    assign ram_write_enabled_o = ram_we_q;
    assign ram_write_data_o    = ram_wdata_q;
    assign rd_valid_o          = rd_pipe_q[RD_LATENCY];
    assign rd_data_o           = ram_read_data_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM with matching read latency and a read-return scoreboard.
module tb_ram_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 19;
    localparam int DW = 3;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req, lock, we;
    logic [NR*AW-1:0]  addr_v;
    logic [NR*DW-1:0]  wdata_v;
    logic [NR-1:0]     gnt, rd_valid;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;

    typedef struct {
        int            due;
        logic [NR-1:0] vec;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdq [0:RL-1];

    ram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)) dut (
        .clock_i             (clk),
        .reset_i             (reset),
        .req_i               (req),
        .lock_i              (lock),
        .we_i                (we),
        .addr_i              (addr_v),
        .wdata_i             (wdata_v),
        .gnt_o               (gnt),
        .rd_valid_o          (rd_valid),
        .rd_data_o           (rd_data),
        .busy_o              (busy),
        .ram_address_o       (ram_addr),
        .ram_write_enabled_o (ram_we),
        .ram_write_data_o    (ram_wdata),
        .ram_read_data_i     (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: q_b valid RL cycles after the command register.
    always @(posedge clk) begin
        for (int k = RL - 1; k > 0; k--) rdq[k] = rdq[k-1];
        rdq[0] = mem[ram_addr];
        if (ram_we === 1'b1) mem[ram_addr] = ram_wdata;
    end
    assign ram_rdata = rdq[RL-1];

    // Read-return scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            n_cmp++; n_fail++;
            $display("FAIL rd_missed: rd_valid %b due at cycle %0d never seen (now %0d)", sb[0].vec, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (rd_valid !== '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid %b at cycle %0d, required none", rd_valid, cyc);
            end else begin
                e = sb.pop_front();
                if (e.due != cyc || e.vec !== rd_valid || e.dat !== rd_data) begin
                    n_fail++;
                    $display("FAIL rd_return: got vec %b data %b at cycle %0d, required vec %b data %b at cycle %0d",
                             rd_valid, rd_data, cyc, e.vec, e.dat, e.due);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 3'b111; lock = '0; we = '0; addr_v = '0; wdata_v = '0;
        tick; tick;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b000)   begin n_fail++; $display("FAIL rst_gnt: got %b want 000", gnt); end
        n_cmp++; if (rd_valid !== 3'b000) begin n_fail++; $display("FAIL rst_rd_valid: got %b want 000", rd_valid); end
        n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            n_fail++; $display("FAIL rst_cmd: got we %b addr %0d data %b want 0/0/000", ram_we, ram_addr, ram_wdata);
        end
        tick;
        reset = 1'b0; req = '0;
    endtask

    task automatic test_round_robin;
        logic [NR-1:0] exp_g;
        req = 3'b111; we = '0; lock = '0;
        addr_v = {19'd30, 19'd20, 19'd10};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_g = 3'b001 << (k % 3);
            n_cmp++;
            if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, exp_g); end
            if (k > 0) begin
                n_cmp++;
                if (ram_addr !== AW'(10 * ((k - 1) % 3 + 1)) || ram_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_addr%0d: got addr %0d we %b want %0d we 0", k, ram_addr, ram_we, 10 * ((k - 1) % 3 + 1));
                end
            end
            sb.push_back('{due: cyc + 1 + RL, vec: exp_g, dat: DW'(k % 3 + 1)});
            tick;
        end
        req = '0;
        @(negedge clk);
        n_cmp++; if (ram_addr !== 19'd30) begin n_fail++; $display("FAIL rr_addr_last: got %0d want 30", ram_addr); end
        repeat (5) tick;
    endtask

    task automatic test_single_write;
        req = 3'b001; we = 3'b001; addr_v[0 +: AW] = 19'd76799; wdata_v[0 +: DW] = 3'b101;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL wr_gnt: got %b want 001", gnt); end
        tick;
        req = '0; we = '0;
        @(negedge clk);
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 19'd76799 || ram_wdata !== 3'b101) begin
            n_fail++; $display("FAIL wr_cmd: got we %b addr %0d data %b want 1/76799/101", ram_we, ram_addr, ram_wdata);
        end
        tick;
        @(negedge clk);
        n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_we_drop: got %b want 0", ram_we); end
        for (int k = 0; k < 3; k++) begin
            tick;
            @(negedge clk);
            n_cmp++; if (rd_valid !== 3'b000) begin n_fail++; $display("FAIL wr_no_rd%0d: got %b want 000", k, rd_valid); end
        end
        tick;
    endtask

    task automatic test_lock_burst;
        req = 3'b111; we = 3'b111; lock = 3'b010; wdata_v = {3'b011, 3'b010, 3'b001};
        for (int k = 1; k <= 6; k++) begin
            lock[1] = (k < 6);
            addr_v[AW +: AW] = AW'(200 + k);
            @(negedge clk);
            n_cmp++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL lk_gnt%0d: got %b want 010", k, gnt); end
            n_cmp++; if (busy !== (k >= 2)) begin n_fail++; $display("FAIL lk_busy%0d: got %b want %b", k, busy, (k >= 2)); end
            if (k > 1) begin
                n_cmp++;
                if (ram_addr !== AW'(199 + k) || ram_we !== 1'b1) begin
                    n_fail++; $display("FAIL lk_cmd%0d: got addr %0d we %b want %0d we 1", k, ram_addr, ram_we, 199 + k);
                end
            end
            tick;
        end
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b100 || busy !== 1'b0) begin n_fail++; $display("FAIL lk_after1: got gnt %b busy %b want 100/0", gnt, busy); end
        tick;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL lk_after2: got %b want 001", gnt); end
        tick;
        req = '0; we = '0; lock = '0;
        tick;
    endtask

    task automatic test_owner_idle;
        req = 3'b010; lock = 3'b010; we = 3'b010; addr_v[AW +: AW] = 19'd300;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL idle_take: got %b want 010", gnt); end
        tick;
        req = 3'b001; we = 3'b001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (gnt !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL idle_hold%0d: got gnt %b busy %b want 000/1", k, gnt, busy); end
            if (k >= 1) begin
                n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL idle_we%0d: got %b want 0", k, ram_we); end
            end
            tick;
        end
        req = 3'b011; lock = '0; we = 3'b011;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL idle_release: got %b want 010", gnt); end
        tick;
        req = 3'b001;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_resume: got gnt %b busy %b want 001/0", gnt, busy); end
        tick;
        req = '0; we = '0;
        tick;
    endtask

    task automatic test_reset_mid_read;
        req = 3'b100; we = 3'b000; lock = '0; addr_v[2*AW +: AW] = 19'd30;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL mr_gnt: got %b want 100", gnt); end
        tick;
        reset = 1'b1; req = 3'b111; we = 3'b111;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL mr_gnt_in_reset: got %b want 000", gnt); end
        tick;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rd_valid !== 3'b000 || busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            n_fail++;
            $display("FAIL mr_outputs: got rd_valid %b busy %b we %b addr %0d data %b want all zero",
                     rd_valid, busy, ram_we, ram_addr, ram_wdata);
        end
        n_cmp++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL mr_first_gnt: got %b want 001", gnt); end
        tick;
        req = '0; we = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (rd_valid !== 3'b000) begin n_fail++; $display("FAIL mr_no_rd%0d: got %b want 000", k, rd_valid); end
            tick;
        end
    endtask

    task automatic test_read_data;
        req = 3'b001; we = 3'b000; lock = '0; addr_v[0 +: AW] = 19'd5;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rd_gnt: got %b want 001", gnt); end
        sb.push_back('{due: cyc + 1 + RL, vec: 3'b001, dat: 3'b110});
        tick;
        req = '0;
        tick;
        @(negedge clk);
        n_cmp++; if (rd_valid !== 3'b000) begin n_fail++; $display("FAIL rd_early: got %b want 000", rd_valid); end
        tick;
        @(negedge clk);
        n_cmp++;
        if (rd_valid !== 3'b001 || rd_data !== 3'b110) begin
            n_fail++; $display("FAIL rd_data: got vec %b data %b want 001/110", rd_valid, rd_data);
        end
        repeat (3) tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[10] = 3'd1; mem[20] = 3'd2; mem[30] = 3'd3; mem[5] = 3'b110;
        for (int k = 0; k < RL; k++) rdq[k] = '0;
        test_reset;
        test_round_robin;
        test_single_write;
        test_lock_burst;
        test_owner_idle;
        test_reset_mid_read;
        test_read_data;
        repeat (4) tick;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d outstanding reads want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the logic-side port (port B) of the frame RAM among several requesters: game logic, the screen-clear engine and the score/text overlay.
- Arbitration is round-robin, with an optional lock so one requester can hold the port for a burst, such as a full-screen clear.
- The RAM command is registered. Read data returns on a shared bus, with a one-hot valid that is delayed to match the RAM read latency.
- Sits between the requesters and the bigram port B pins, in the same clock domain as game_logic.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 19, RAM address width (320x240 frame)
- DATA_W, 3, RAM data width (RGB pixel)
- RD_LATENCY, 2, cycles from the RAM command register to valid q_b at this block's input

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  request per requester; held until granted
- lock  in  NUM_REQ  when set with the granted request, keep ownership after this grant
- we  in  NUM_REQ  1 = write, 0 = read
- addr  in  NUM_REQ*ADDR_W  packed addresses; requester i in [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot, combinational; request accepted this cycle
- rd_valid  out  NUM_REQ  one-hot; rd_data belongs to requester i this cycle
- rd_data  out  DATA_W  read data (ram_read_data passed through)
- busy  out  1  a lock is currently held
- ram_address  out  ADDR_W  to bigram address_b (registered)
- ram_write_enabled  out  1  to bigram wren_b (registered)
- ram_write_data  out  DATA_W  to bigram data_b (registered)
- ram_read_data  in  DATA_W  from bigram q_b

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - gnt = 0, rd_valid = 0, busy = 0
  - ram_write_enabled = 0, ram_address = 0, ram_write_data = 0
  - round-robin pointer last = NUM_REQ-1, so requester 0 wins first
  - lock owner cleared; read-tag pipeline cleared
- Arbitration when not locked:
  - Search order is last+1, last+2, … modulo NUM_REQ.
  - The first asserted req gets gnt for exactly that cycle.
  - At most one gnt bit is set per cycle. Throughput is 1 access per cycle.
- Arbitration when locked (busy = 1):
  - Only the owner can be granted.
  - Other requests stall, with no gnt, regardless of the pointer.
- Lock handling:
  - A grant to i with lock[i] = 1 sets owner = i and busy = 1 from the next cycle.
  - A grant to the owner with lock[i] = 0 releases the lock from the next cycle.
  - If the owner drops req while still locked, the lock stays held: busy stays 1 and the port idles.
- Pointer: on every grant to i, last <= i.
- Command (cycle t = grant cycle), registered at t+1:
  - ram_address = addr[i], ram_write_data = wdata[i], ram_write_enabled = we[i].
  - With no grant at t, ram_write_enabled = 0 at t+1.
  - ram_address and ram_write_data hold their previous values when there is no grant.
- Requester contract:
  - addr, we and wdata are sampled only in the gnt cycle.
  - The requester may change them, or drop req, the cycle after gnt.
  - req held high after gnt means a new request.
- Read return:
  - A read granted at t asserts rd_valid[i] at t+1+RD_LATENCY for one cycle.
  - rd_data = ram_read_data combinationally.
  - Writes produce no rd_valid.
  - Back-to-back reads return in grant order, one per cycle.
- Reset mid-operation: in-flight rd_valid tags are discarded, so no rd_valid occurs after reset. Any command already registered completes at the RAM.
- Simultaneous events:
  - Lock release and another pending request in the same cycle: the release takes effect next cycle, and normal round-robin resumes then.
  - All requesters asserting: service order is 0,1,2,0,1,2,…
- Width rule: no arithmetic on addr or data; all fields are passed through bit-exact.

Test Plan:
- Reset then req = 3'b111, all reads, addr0 = 10, addr1 = 20, addr2 = 30, held for 6 cycles.
  - Required: gnt sequence 001, 010, 100, 001, 010, 100.
  - Required: ram_address 10, 20, 30, … one cycle later.
  - Required: rd_valid 001, 010, 100 starting 3 cycles after the first gnt.
- Single write: req0 = 1, we0 = 1, addr0 = 19'd76799, wdata0 = 3'b101.
  - Required: gnt0 in the same cycle.
  - Required: next cycle ram_write_enabled = 1, ram_address = 76799, ram_write_data = 101.
  - Required: following cycle ram_write_enabled = 0; no rd_valid.
- Lock burst: req1 with lock1 = 1 for 5 writes, then lock1 = 0 on the 6th; req0 and req2 held high throughout.
  - Required: gnt = 010 for 6 consecutive cycles; busy = 1 during cycles 2..6.
  - Required: then gnt alternates 100, 001.
- Owner idle while locked: lock held, req1 dropped for 4 cycles while req0 = 1.
  - Required: no gnt, ram_write_enabled = 0, busy = 1 throughout.
- Reset mid-read: grant a read to req2, assert reset 1 cycle later.
  - Required: rd_valid never asserts; all outputs at reset values the cycle after reset.
  - Required: first grant after reset goes to requester 0 when all request.
- Read data path: preload RAM addr 5 = 3'b110, req0 read addr 5.
  - Required: rd_valid = 001 with rd_data = 110 exactly 1+RD_LATENCY cycles after gnt.
